// File: rtl/multi_cycle_controller_if.sv
// Control bus between a multi-cycle RISC-V datapath and its controller.
// The master modport is the controller side; the slave modport is the datapath side.
interface multi_cycle_controller_if;
    logic [6:0] OP;
    logic [2:0] funct3;
    logic       funct7;
    logic       ZF;
    logic       SF;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       mem_req;
    logic       illegal;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    modport master (
        input  OP, funct3, funct7, ZF, SF, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, mem_req, illegal,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
    );

    modport slave (
        output OP, funct3, funct7, ZF, SF, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, mem_req, illegal,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V control FSM: registered state, combinational (Moore/Mealy) outputs.
// All outputs are forced to 0 while rst_n is low so an abort takes effect without waiting for clk.
module multi_cycle_controller (
    input  logic                          clk,
    input  logic                          rst_n,
    multi_cycle_controller_if.master      bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    w_next = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.OP)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_RTYPE:          w_next = EXECR;
                    OP_ITYPE:          w_next = EXECI;
                    OP_BR:             w_next = BRANCH;
                    OP_JAL:            w_next = JAL;
                    default:           w_next = TRAP;
                endcase
            end
            MEMADR:   w_next = (bus.OP == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWB:    w_next = FETCH;
            MEMWRITE: w_next = bus.mem_ready ? FETCH : MEMWRITE;
            EXECR:    w_next = ALUWB;
            EXECI:    w_next = ALUWB;
            ALUWB:    w_next = FETCH;
            BRANCH:   w_next = FETCH;
            JAL:      w_next = ALUWB;
            TRAP:     w_next = TRAP;
            default:  w_next = TRAP;
        endcase
    end

    // funct7 only selects sub for register-register ops; addi never subtracts.
    always_comb begin
        w_alu_op = 3'b000;
        case (bus.funct3)
            3'b000:  w_alu_op = ((r_state == EXECR) && bus.funct7) ? 3'b001 : 3'b000;
            3'b010:  w_alu_op = 3'b101;
            3'b110:  w_alu_op = 3'b011;
            3'b111:  w_alu_op = 3'b010;
            default: w_alu_op = 3'b000;
        endcase
    end

    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.mem_req    = 1'b0;
        bus.illegal    = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.ALUControl = 3'b000;
        bus.state      = r_state;

        case (bus.OP)
            OP_STORE: bus.ImmSrc = 2'b01;
            OP_BR:    bus.ImmSrc = 2'b10;
            OP_JAL:   bus.ImmSrc = 2'b11;
            default:  bus.ImmSrc = 2'b00;
        endcase

        case (r_state)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            EXECR: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = w_alu_op;
            end
            EXECI: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = w_alu_op;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = 3'b001;
                case (bus.funct3)
                    3'b000:  bus.PCWrite = bus.ZF;
                    3'b001:  bus.PCWrite = ~bus.ZF;
                    3'b100:  bus.PCWrite = bus.SF;
                    default: bus.PCWrite = 1'b0;
                endcase
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            TRAP: begin
                bus.illegal = 1'b1;
            end
            default: begin
                bus.illegal = 1'b0;
            end
        endcase

        if (!rst_n) begin
            bus.PCWrite    = 1'b0;
            bus.AdrSrc     = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.mem_req    = 1'b0;
            bus.illegal    = 1'b0;
            bus.ResultSrc  = 2'b00;
            bus.ALUSrcA    = 2'b00;
            bus.ALUSrcB    = 2'b00;
            bus.ImmSrc     = 2'b00;
            bus.ALUControl = 3'b000;
            bus.state      = 4'd0;
        end
    end
endmodule
